// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler that shares one byte-level I2C master engine between
// NUM_REQ requesters, sequencing START, address+R/W, one data byte and STOP.
module i2c_txn_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_nack,
  output logic                 rsp_timeout,
  output logic [1:0]           eng_cmd,
  output logic                 eng_cmd_valid,
  input  logic                 eng_cmd_ready,
  output logic [7:0]           eng_wdata,
  output logic                 eng_rd_nack,
  input  logic                 eng_done,
  input  logic                 eng_ack,
  input  logic [7:0]           eng_rdata
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_DATA, S_STOP, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            wait_q, wait_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            nack_q, nack_d;
  logic            tmo_q, tmo_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic            rw_q, rw_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;

  logic            any_req;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   scan_idx;
  logic            cmd_state;
  logic            accept;
  logic            done;
  logic            tmo_hit;

  // Scan downward so the last hit is the nearest requester after rr_ptr.
  always_comb begin
    any_req  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      scan_idx = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        any_req = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign cmd_state = (state_q == S_START) || (state_q == S_ADDR) ||
                     (state_q == S_DATA)  || (state_q == S_STOP);
  assign accept    = cmd_state && !wait_q && eng_cmd_ready;
  assign done      = cmd_state && wait_q && eng_done;
  assign tmo_hit   = cmd_state && !accept && !done &&
                     (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_START;
      S_START: if (done) state_d = S_ADDR;
               else if (tmo_hit) state_d = S_STOP;
      S_ADDR:  if (done) state_d = eng_ack ? S_STOP : S_DATA;
               else if (tmo_hit) state_d = S_STOP;
      S_DATA:  if (done || tmo_hit) state_d = S_STOP;
      S_STOP:  if (done || tmo_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wait_d   = wait_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    nack_d   = nack_q;
    tmo_d    = tmo_q;
    grant_d  = grant_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    // Every state entry starts a fresh command: idle handshake, zeroed timer.
    if (state_d != state_q) begin
      wait_d = 1'b0;
      cnt_d  = '0;
    end else if (cmd_state) begin
      cnt_d = cnt_q + CW'(1);
      if (accept) wait_d = 1'b1;
    end
    if (state_q == S_IDLE && any_req) begin
      rr_ptr_d = gnt_idx;
      grant_d  = gnt_idx;
      nack_d   = 1'b0;
      tmo_d    = 1'b0;
      rw_d     = req_rw[gnt_idx];
      addr_d   = req_addr[int'(gnt_idx)*7 +: 7];
      wdata_d  = req_wdata[int'(gnt_idx)*8 +: 8];
      rdata_d  = '0;
    end
    if (tmo_hit) tmo_d = 1'b1;
    if (done && state_q == S_ADDR && eng_ack) nack_d = 1'b1;
    if (done && state_q == S_DATA) begin
      if (rw_q)         rdata_d = eng_rdata;
      else if (eng_ack) nack_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q   <= 1'b0;
      cnt_q    <= '0;
      rr_ptr_q <= PW'(NUM_REQ - 1);
      nack_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      nack_q   <= nack_d;
      tmo_q    <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    grant_q <= grant_d;
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign eng_rd_nack = 1'b1;

  always_comb begin
    eng_cmd_valid = 1'b0;
    eng_cmd       = CMD_START;
    eng_wdata     = '0;
    rsp_valid     = '0;
    rsp_nack      = 1'b0;
    rsp_timeout   = 1'b0;
    rsp_rdata     = '0;
    unique case (state_q)
      S_START: eng_cmd_valid = !wait_q;
      S_ADDR: begin
        eng_cmd_valid = !wait_q;
        if (!wait_q) begin
          eng_cmd   = CMD_WRITE;
          eng_wdata = {addr_q, rw_q};
        end
      end
      S_DATA: begin
        eng_cmd_valid = !wait_q;
        if (!wait_q) begin
          eng_cmd   = rw_q ? CMD_READ : CMD_WRITE;
          eng_wdata = rw_q ? 8'h00 : wdata_q;
        end
      end
      S_STOP: begin
        eng_cmd_valid = !wait_q;
        if (!wait_q) eng_cmd = CMD_STOP;
      end
      S_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        rsp_nack           = nack_q;
        rsp_timeout        = tmo_q;
        rsp_rdata          = (rw_q && !nack_q && !tmo_q) ? rdata_q : 8'h00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Scoreboard bench for i2c_txn_scheduler: a byte-level engine model checks each
// issued command, a monitor checks each response pulse against expected queues.
module tb_i2c_txn_scheduler;

  localparam int NUM_REQ = 4;
  localparam int TMO     = 16;
  localparam int LAT     = 3;
  localparam logic [6:0] SLV = 7'h2a;
  localparam logic [7:0] RD_BYTE = 8'ha5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_rw;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_rdata;
  logic                 rsp_nack;
  logic                 rsp_timeout;
  logic [1:0]           eng_cmd;
  logic                 eng_cmd_valid;
  logic                 eng_cmd_ready;
  logic [7:0]           eng_wdata;
  logic                 eng_rd_nack;
  logic                 eng_done;
  logic                 eng_ack;
  logic [7:0]           eng_rdata;

  i2c_txn_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .rsp_timeout(rsp_timeout), .eng_cmd(eng_cmd), .eng_cmd_valid(eng_cmd_valid),
    .eng_cmd_ready(eng_cmd_ready), .eng_wdata(eng_wdata), .eng_rd_nack(eng_rd_nack),
    .eng_done(eng_done), .eng_ack(eng_ack), .eng_rdata(eng_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] cmd; logic [7:0] wdata;} cmd_t;
  typedef struct packed {logic [1:0] idx; logic nack; logic tmo; logic [7:0] rdata;} rsp_t;

  cmd_t exp_cmd_q[$];
  rsp_t exp_rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  int   acc_cnt = 0;
  int   start_cyc = 0;
  int   txn_left[NUM_REQ];
  logic drop_done = 1'b0;
  logic tmo_armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] c, input logic [7:0] wd);
    cmd_t e;
    e.cmd = c;
    e.wdata = wd;
    exp_cmd_q.push_back(e);
  endtask

  task automatic push_rsp(input int idx, input logic nack, input logic tmo, input logic [7:0] rd);
    rsp_t r;
    r.idx = 2'(idx);
    r.nack = nack;
    r.tmo = tmo;
    r.rdata = rd;
    exp_rsp_q.push_back(r);
  endtask

  // Expected command stream and response for one complete transaction.
  task automatic push_txn(input int idx, input logic rw, input logic [6:0] addr,
                          input logic [7:0] wd);
    logic present;
    present = (addr == SLV);
    push_cmd(2'd0, 8'h00);
    push_cmd(2'd1, {addr, rw});
    if (present) push_cmd(rw ? 2'd2 : 2'd1, wd);
    push_cmd(2'd3, 8'h00);
    push_rsp(idx, !present, 1'b0, (rw && present) ? RD_BYTE : 8'h00);
  endtask

  task automatic set_req(input int idx, input logic rw, input logic [6:0] addr,
                         input logic [7:0] wd);
    req_rw[idx] = rw;
    req_addr[idx*7 +: 7] = addr;
    req_wdata[idx*8 +: 8] = wd;
  endtask

  task automatic wait_rsps(input int target);
    int t;
    t = 0;
    while (rsp_cnt < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("rsp_arrived", 32'(rsp_cnt >= target), 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, 32'({eng_cmd_valid, eng_cmd, eng_wdata, rsp_valid, rsp_nack,
                     rsp_timeout, rsp_rdata}), 32'd0);
    check("rd_nack_const", 32'(eng_rd_nack), 32'd1);
  endtask

  // Engine model: accepts a command one cycle after valid, finishes LAT cycles later.
  initial begin
    logic       busy;
    int         lat_left;
    logic [1:0] cur_cmd;
    logic [7:0] cur_wd;
    logic       addr_phase;
    logic       is_addr;
    cmd_t       e;
    busy = 1'b0; lat_left = 0; cur_cmd = '0; cur_wd = '0; addr_phase = 1'b0; is_addr = 1'b0;
    eng_cmd_ready = 1'b0; eng_done = 1'b0; eng_ack = 1'b0; eng_rdata = '0;
    forever begin
      @(negedge clk);
      eng_cmd_ready = 1'b0;
      eng_done = 1'b0;
      eng_ack = 1'b0;
      eng_rdata = '0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        lat_left--;
        if (lat_left == 0) begin
          busy = 1'b0;
          if (drop_done) begin
            drop_done = 1'b0;
          end else begin
            eng_done = 1'b1;
            eng_ack = is_addr && (cur_wd[7:1] != SLV);
            eng_rdata = (cur_cmd == 2'd2) ? RD_BYTE : 8'h00;
          end
        end
      end else if (eng_cmd_valid) begin
        eng_cmd_ready = 1'b1;
        busy = 1'b1;
        lat_left = LAT;
        cur_cmd = eng_cmd;
        cur_wd = eng_wdata;
        acc_cnt++;
        if (cur_cmd == 2'd0) addr_phase = 1'b1;
        is_addr = (cur_cmd == 2'd1) && addr_phase;
        if (cur_cmd == 2'd1) addr_phase = 1'b0;
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected actual_cmd=%0d wdata=0x%0h expected=none", cur_cmd, cur_wd);
        end else begin
          e = exp_cmd_q.pop_front();
          check("eng_cmd", 32'(cur_cmd), 32'(e.cmd));
          if (e.cmd == 2'd1) check("eng_wdata", 32'(cur_wd), 32'(e.wdata));
          if (e.cmd == 2'd2) check("eng_rd_nack", 32'(eng_rd_nack), 32'd1);
        end
        if (cur_cmd == 2'd0) start_cyc = cyc;
        if (cur_cmd == 2'd3 && tmo_armed) begin
          tmo_armed = 1'b0;
          check("tmo_stop_delay", 32'(cyc - start_cyc), 32'd16);
        end
      end
    end
  end

  // Response monitor; also plays the requesters dropping req_valid on completion.
  initial begin
    rsp_t r;
    logic [NUM_REQ-1:0] ev;
    forever begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        if (exp_rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=%b expected=none", rsp_valid);
        end else begin
          r = exp_rsp_q.pop_front();
          ev = '0;
          ev[r.idx] = 1'b1;
          check("rsp_valid", 32'(rsp_valid), 32'(ev));
          check("rsp_nack", 32'(rsp_nack), 32'(r.nack));
          check("rsp_timeout", 32'(rsp_timeout), 32'(r.tmo));
          check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (rsp_valid[i]) begin
            txn_left[i]--;
            if (txn_left[i] <= 0) req_valid[i] = 1'b0;
          end
        end
        rsp_cnt++;
      end
    end
  end

  initial begin
    int base;
    int t;
    logic [7:0] wd4 [NUM_REQ];
    logic       rw4 [NUM_REQ];
    rst_n = 1'b0;
    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) txn_left[i] = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write 0x74 to 0x2a from requester 0
    set_req(0, 1'b0, 7'h2a, 8'h74);
    push_txn(0, 1'b0, 7'h2a, 8'h74);
    txn_left[0] = 1;
    req_valid[0] = 1'b1;
    wait_rsps(1);

    // 2: read from 0x2a by requester 1
    set_req(1, 1'b1, 7'h2a, 8'h00);
    push_txn(1, 1'b1, 7'h2a, 8'h00);
    txn_left[1] = 1;
    req_valid[1] = 1'b1;
    wait_rsps(2);

    // 3: write to absent slave 0x11 by requester 3
    set_req(3, 1'b0, 7'h11, 8'h99);
    push_txn(3, 1'b0, 7'h11, 8'h99);
    txn_left[3] = 1;
    req_valid[3] = 1'b1;
    wait_rsps(3);

    // 4: all requesters held for two transactions each
    wd4[0] = 8'h10; wd4[1] = 8'h00; wd4[2] = 8'h30; wd4[3] = 8'h40;
    rw4[0] = 1'b0;  rw4[1] = 1'b1;  rw4[2] = 1'b0;  rw4[3] = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, rw4[i], 7'h2a, wd4[i]);
      txn_left[i] = 2;
    end
    for (int k = 0; k < 8; k++) push_txn(k % NUM_REQ, rw4[k % NUM_REQ], 7'h2a, wd4[k % NUM_REQ]);
    req_valid = 4'b1111;
    wait_rsps(11);

    // 5: START completion suppressed -> timeout, STOP, timeout response
    set_req(2, 1'b0, 7'h2a, 8'h55);
    push_cmd(2'd0, 8'h00);
    push_cmd(2'd3, 8'h00);
    push_rsp(2, 1'b0, 1'b1, 8'h00);
    drop_done = 1'b1;
    tmo_armed = 1'b1;
    txn_left[2] = 1;
    req_valid[2] = 1'b1;
    wait_rsps(12);
    check("tmo_stop_seen", 32'(tmo_armed), 32'd0);

    // 6: reset while waiting on the DATA write of requester 3, req2 pending
    set_req(3, 1'b0, 7'h2a, 8'h66);
    set_req(2, 1'b1, 7'h2a, 8'h00);
    push_cmd(2'd0, 8'h00);
    push_cmd(2'd1, 8'h54);
    push_cmd(2'd1, 8'h66);
    push_txn(2, 1'b1, 7'h2a, 8'h00);
    txn_left[2] = 1;
    txn_left[3] = 1;
    base = acc_cnt;
    req_valid[3] = 1'b1;
    req_valid[2] = 1'b1;
    t = 0;
    while (acc_cnt < base + 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("data_cmd_reached", 32'(acc_cnt >= base + 3), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid[3] = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    wait_rsps(13);

    repeat (10) @(negedge clk);
    check("cmd_queue_left", 32'(exp_cmd_q.size()), 32'd0);
    check("rsp_queue_left", 32'(exp_rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
